// File: rtl/decimal_pkg.sv
// Shared constants for the decimal/binary converters on the scoreboard input and output paths.
// Holds the FSM state encoding, the BCD digit limits and the double-dabble adjust constants.
package decimal_pkg;

   localparam int DEF_DIGITS = 2;
   localparam int DEF_BIN_W  = 7;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] ADJ   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam logic [3:0] DD_ADJ_THRESH = 4'd8;
   localparam logic [3:0] DD_ADJ_VALUE  = 4'd3;

endpackage

// File: rtl/dd_nibble_sub3.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the nibble is 8 or more.
// This undoes the +10 weight a tens bit gains when it is shifted down into the ones position.
module dd_nibble_sub3
   import decimal_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [3:0] o_nibble
);

   assign o_nibble = (i_nibble >= DD_ADJ_THRESH) ? (i_nibble - DD_ADJ_VALUE) : i_nibble;

endmodule

// File: rtl/decimal_to_bin.sv
// Two-digit BCD to binary converter using reverse double-dabble, one shift or adjust per cycle.
// Invalid digits still take the full latency; the result is then forced to zero with err_o set.
module decimal_to_bin
   import decimal_pkg::*;
#(
   parameter int DIGITS = DEF_DIGITS,
   parameter int BIN_W  = DEF_BIN_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [3:0]       tens_i,
   input  logic [3:0]       ones_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [BIN_W-1:0] bin_o,
   output logic             err_o
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   if (DIGITS != 2) begin : g_bad_digits
      $error("decimal_to_bin: only DIGITS=2 is supported");
   end
   if ((10 ** DIGITS - 1) >= (2 ** BIN_W)) begin : g_bad_bin_w
      $error("decimal_to_bin: BIN_W too narrow for 10**DIGITS-1");
   end

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [BCD_W-1:0] r_bcd;
   logic [BIN_W-1:0] r_bin;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic [BIN_W-1:0] r_bin_q;
   logic             r_err_q;
   logic             r_valid;
   logic [BCD_W-1:0] w_bcd_adj;
   logic             w_load;
   logic             w_shift;
   logic             w_adj;
   logic             w_done;
   logic             w_last;

   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      dd_nibble_sub3 u_sub3 (
         .i_nibble (r_bcd[4*d +: 4]),
         .o_nibble (w_bcd_adj[4*d +: 4])
      );
   end

   assign w_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = IDLE;
      case (r_state)
         IDLE:    w_state_nxt = start_i ? SHIFT : IDLE;
         SHIFT:   w_state_nxt = ADJ;
         ADJ:     w_state_nxt = w_last ? DONE : SHIFT;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_load  = (r_state == IDLE) && start_i;
      w_shift = (r_state == SHIFT);
      w_adj   = (r_state == ADJ);
      w_done  = (r_state == DONE);
      busy_o  = (r_state != IDLE);
   end

   // Work register is {bcd, bin}; a right shift moves the lowest BCD bit into the binary MSB.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_bcd   <= '0;
         r_bin   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_bin_q <= '0;
         r_err_q <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_load) begin
            r_bcd <= {tens_i, ones_i};
            r_bin <= '0;
            r_cnt <= '0;
            r_err <= (tens_i > BCD_MAX_DIGIT) | (ones_i > BCD_MAX_DIGIT);
         end
         if (w_shift) begin
            r_bcd <= {1'b0, r_bcd[BCD_W-1:1]};
            r_bin <= {r_bcd[0], r_bin[BIN_W-1:1]};
         end
         if (w_adj) begin
            r_bcd <= w_bcd_adj;
            if (!w_last) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         if (w_done) begin
            r_valid <= 1'b1;
            r_bin_q <= r_err ? '0 : r_bin;
            r_err_q <= r_err;
         end
      end
   end

   assign valid_o = r_valid;
   assign bin_o   = r_bin_q;
   assign err_o   = r_err_q;

endmodule

// File: tb/tb_decimal_to_bin.sv
// Directed bench for decimal_to_bin: latency, full legal sweep, invalid digits, busy-ignore,
// mid-conversion reset and held start.
module tb_decimal_to_bin;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [3:0] tens_i;
   logic [3:0] ones_i;
   logic       busy_o;
   logic       valid_o;
   logic [6:0] bin_o;
   logic       err_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   decimal_to_bin dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .tens_i  (tens_i),
      .ones_i  (ones_i),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .bin_o   (bin_o),
      .err_o   (err_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Counts edges until valid_o is seen; returns budget if it never arrives.
   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!valid_o && n < budget);
   endtask

   task automatic do_conv(input logic [3:0] t, input logic [3:0] o,
                          input int exp_bin, input logic exp_err, input string tag);
      int n;
      tens_i  = t;
      ones_i  = o;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      tens_i  = 4'hF;
      ones_i  = 4'hF;
      check({tag, "_busy"}, busy_o, 1);
      wait_valid(40, n);
      check({tag, "_lat"}, n, 15);
      check({tag, "_bin"}, bin_o, exp_bin);
      check({tag, "_err"}, err_o, exp_err);
      check({tag, "_busy_in_valid"}, busy_o, 0);
      step();
      check({tag, "_valid_one_cycle"}, valid_o, 0);
      check({tag, "_bin_held"}, bin_o, exp_bin);
   endtask

   initial begin
      int n;
      int nv;
      int t_valid;
      int v_bin;
      logic stable;
      logic [6:0] held;

      rst_ni  = 1'b0;
      start_i = 1'b1;
      tens_i  = 4'd9;
      ones_i  = 4'd9;
      repeat (3) step();
      check("rst_bin", bin_o, 0);
      check("rst_err", err_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      start_i = 1'b0;
      rst_ni  = 1'b1;
      step();

      do_conv(4'd9, 4'd9, 99, 1'b0, "c99");
      do_conv(4'd4, 4'd2, 42, 1'b0, "c42");
      do_conv(4'd0, 4'd0, 0, 1'b0, "c00");
      do_conv(4'hA, 4'd3, 0, 1'b1, "bad_tens");
      do_conv(4'd1, 4'd7, 17, 1'b0, "after_err");
      do_conv(4'd2, 4'hC, 0, 1'b1, "bad_ones");

      // Start while busy is ignored: one result only.
      tens_i  = 4'd5;
      ones_i  = 4'd0;
      start_i = 1'b1;
      step();
      nv = 0;
      t_valid = 0;
      v_bin = 0;
      for (int e = 1; e <= 40; e++) begin
         start_i = (e == 3 || e == 10);
         tens_i  = 4'd2;
         ones_i  = 4'd1;
         step();
         if (valid_o) begin
            nv++;
            t_valid = e;
            v_bin = int'(bin_o);
         end
      end
      start_i = 1'b0;
      check("ign_count", nv, 1);
      check("ign_time", t_valid, 15);
      check("ign_bin", v_bin, 50);

      // Back-to-back sweep of every legal pair, restarting in each valid cycle.
      tens_i  = 4'd0;
      ones_i  = 4'd0;
      start_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         start_i = 1'b0;
         wait_valid(40, n);
         check("sweep_lat", n, 15);
         check("sweep_bin", bin_o, (i / 10) * 10 + (i % 10));
         check("sweep_err", err_o, 0);
         if (i < 99) begin
            tens_i  = 4'((i + 1) / 10);
            ones_i  = 4'((i + 1) % 10);
            start_i = 1'b1;
         end
      end
      step();

      // Held start: each pulse is one accept edge plus 15 cycles after the previous one.
      tens_i  = 4'd3;
      ones_i  = 4'd3;
      start_i = 1'b1;
      wait_valid(40, n);
      check("hold_first", n, 16);
      for (int p = 0; p < 3; p++) begin
         held   = bin_o;
         stable = 1'b1;
         n = 0;
         do begin
            step();
            n++;
            if (!valid_o && bin_o !== held) stable = 1'b0;
         end while (!valid_o && n < 40);
         check("hold_period", n, 16);
         check("hold_stable", stable, 1);
         check("hold_bin", bin_o, 33);
      end
      start_i = 1'b0;
      step();
      check("hold_stop", busy_o, 0);

      // Reset in the middle of a conversion aborts it.
      tens_i  = 4'd6;
      ones_i  = 4'd4;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (6) step();
      rst_ni = 1'b0;
      step();
      check("abort_valid", valid_o, 0);
      check("abort_bin", bin_o, 0);
      check("abort_err", err_o, 0);
      check("abort_busy", busy_o, 0);
      rst_ni = 1'b1;
      nv = 0;
      for (int e = 0; e < 20; e++) begin
         step();
         if (valid_o) nv++;
      end
      check("abort_no_valid", nv, 0);
      do_conv(4'd6, 4'd4, 64, 1'b0, "restart");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
